// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding imem requests feeding a small
// prefetch FIFO, with branch redirect that flushes the prefetched stream.
module instruction_fetch #(
  parameter logic [31:0] reset_pc = 32'h00010000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t           state_reg;
  logic [31:0]      fetch_pc_reg;
  logic [31:0]      flush_addr_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic [31:0]      target_pc;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after;

  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign push        = (state_reg == REQ) && imem_ack && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign count_after = count_reg + CNT_W'(push) - CNT_W'(pop);

  assign imem_req    = (state_reg != IDLE);
  // While flushing, the abandoned request's address must stay on the bus.
  assign imem_addr   = (state_reg == FLUSH) ? flush_addr_reg : fetch_pc_reg;
  assign instr_valid = (count_reg != '0);
  assign instr_out   = data_mem[head_reg];
  assign instr_pc    = pc_mem[head_reg];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= reset_pc;
      flush_addr_reg <= reset_pc;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= target_pc;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      case (state_reg)
        REQ: begin
          if (!imem_ack) begin
            flush_addr_reg <= fetch_pc_reg;
            state_reg      <= FLUSH;
          end
        end
        FLUSH:   if (imem_ack) state_reg <= REQ;
        default: state_reg <= REQ;
      endcase
    end else begin
      if (push) begin
        tail_reg     <= tail_reg + 1'b1;
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (pop) head_reg <= head_reg + 1'b1;
      count_reg <= count_after;
      case (state_reg)
        IDLE:    if (count_reg < DEPTH_C) state_reg <= REQ;
        REQ:     if (imem_ack && (count_after >= DEPTH_C)) state_reg <= IDLE;
        FLUSH:   if (imem_ack) state_reg <= REQ;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Entries are cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[tail_reg]   <= fetch_pc_reg;
      data_mem[tail_reg] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, back-pressure,
// redirect/flush cases, reset mid-request and PC wraparound.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  logic        w_reset;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr_out;
  logic [31:0] w_instr_pc;

  int tests;
  int fails;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  instruction_fetch #(.reset_pc(32'hFFFFFFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_data(w_imem_data), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .instr_out(w_instr_out), .instr_pc(w_instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEADBEEF; instr_ready = 1'b1;
    step(); step();
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %h want 0", instr_valid); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %h want 0", imem_req); end
    tests++; if (imem_addr !== 32'h00010000) begin fails++; $display("FAIL rst_addr got %h want 00010000", imem_addr); end
    tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL rst_out got %h want 0", instr_out); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h want 0", instr_pc); end
    reset = 1'b1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rel_req_early got %h want 0", imem_req); end
    step();
    imem_ack = 1'b0;
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rel_req got %h want 1", imem_req); end
    tests++; if (imem_addr !== 32'h00010000) begin fails++; $display("FAIL rel_addr got %h want 00010000", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rel_ack_ignored got %h want 0", instr_valid); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = 32'h00010000 + 32'(4 * k);
      tests++; if (imem_req !== 1'b1 || imem_addr !== exp) begin fails++; $display("FAIL stream_addr%0d got req=%h addr=%h want 1 %h", k, imem_req, imem_addr, exp); end
      step();
      imem_ack = 1'b1; imem_data = exp;
      step();
      imem_ack = 1'b0;
      tests++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr_out !== exp) begin fails++; $display("FAIL stream_out%0d got v=%h pc=%h out=%h want 1 %h %h", k, instr_valid, instr_pc, instr_out, exp, exp); end
    end
    $display("[TB] test_stream done");
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_data = 32'h00010000;
    step();
    tests++; if (instr_pc !== 32'h00010000 || imem_addr !== 32'h00010004) begin fails++; $display("FAIL bp_first got pc=%h addr=%h want 00010000 00010004", instr_pc, imem_addr); end
    imem_data = 32'h00010004;
    step();
    imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h00010000 || instr_out !== 32'h00010000) begin
        fails++; $display("FAIL bp_hold%0d got req=%h v=%h pc=%h out=%h want 0 1 00010000 00010000", k, imem_req, instr_valid, instr_pc, instr_out);
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00010004 || instr_out !== 32'h00010004) begin fails++; $display("FAIL bp_second got v=%h pc=%h out=%h want 1 00010004", instr_valid, instr_pc, instr_out); end
    step();
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00010008) begin fails++; $display("FAIL bp_resume got v=%h req=%h addr=%h want 0 1 00010008", instr_valid, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'h00010008;
    step();
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00010008) begin fails++; $display("FAIL bp_third got v=%h pc=%h want 1 00010008", instr_valid, instr_pc); end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_redirect_flush();
    do_reset();
    instr_ready = 1'b1;
    imem_ack = 1'b1; imem_data = 32'h00010000;
    step();
    imem_data = 32'h00010004;
    step();
    tests++; if (instr_pc !== 32'h00010004 || imem_addr !== 32'h00010008) begin fails++; $display("FAIL rf_pre got pc=%h addr=%h want 00010004 00010008", instr_pc, imem_addr); end
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h00020002;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h00010008 || instr_valid !== 1'b0) begin fails++; $display("FAIL rf_flush got req=%h addr=%h v=%h want 1 00010008 0", imem_req, imem_addr, instr_valid); end
    step();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h00010008) begin fails++; $display("FAIL rf_hold got req=%h addr=%h want 1 00010008", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'hBAD00008;
    step();
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00020000) begin fails++; $display("FAIL rf_target got v=%h req=%h addr=%h want 0 1 00020000", instr_valid, imem_req, imem_addr); end
    imem_data = 32'h00020000;
    step();
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00020000 || instr_out !== 32'h00020000) begin fails++; $display("FAIL rf_out got v=%h pc=%h out=%h want 1 00020000", instr_valid, instr_pc, instr_out); end
    $display("[TB] test_redirect_flush done");
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    imem_ack = 1'b1; imem_data = 32'h00010000;
    step();
    instr_ready = 1'b1; imem_data = 32'h00010004;
    redirect_valid = 1'b1; redirect_pc = 32'h00030000;
    step();
    redirect_valid = 1'b0;
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00030000) begin fails++; $display("FAIL rap_target got v=%h req=%h addr=%h want 0 1 00030000", instr_valid, imem_req, imem_addr); end
    imem_data = 32'h00030000;
    step();
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00030000 || instr_out !== 32'h00030000) begin fails++; $display("FAIL rap_out got v=%h pc=%h out=%h want 1 00030000", instr_valid, instr_pc, instr_out); end
    step();
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rap_drained got v=%h want 0", instr_valid); end
    $display("[TB] test_redirect_ack_pop done");
  endtask

  task automatic test_redirect_full();
    do_reset();
    imem_ack = 1'b1; imem_data = 32'h00010000;
    step();
    imem_data = 32'h00010004;
    step();
    imem_ack = 1'b0;
    tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin fails++; $display("FAIL rfull_pre got req=%h v=%h want 0 1", imem_req, instr_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h00040007;
    step();
    redirect_valid = 1'b0;
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00040004) begin fails++; $display("FAIL rfull_target got v=%h req=%h addr=%h want 0 1 00040004", instr_valid, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'h00040004;
    step();
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00040004) begin fails++; $display("FAIL rfull_out got v=%h pc=%h want 1 00040004", instr_valid, instr_pc); end
    $display("[TB] test_redirect_full done");
  endtask

  task automatic test_flush_double();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h00050000;
    step();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h00010000 || instr_valid !== 1'b0) begin fails++; $display("FAIL fd_flush got req=%h addr=%h v=%h want 1 00010000 0", imem_req, imem_addr, instr_valid); end
    redirect_pc = 32'h00060009;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h00010000) begin fails++; $display("FAIL fd_hold got req=%h addr=%h want 1 00010000", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'hBAD10000;
    step();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h00060008 || instr_valid !== 1'b0) begin fails++; $display("FAIL fd_target got req=%h addr=%h v=%h want 1 00060008 0", imem_req, imem_addr, instr_valid); end
    imem_data = 32'h00060008; instr_ready = 1'b1;
    step();
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00060008 || instr_out !== 32'h00060008) begin fails++; $display("FAIL fd_out got v=%h pc=%h out=%h want 1 00060008", instr_valid, instr_pc, instr_out); end
    $display("[TB] test_flush_double done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ack = 1'b1; imem_data = 32'h00010000;
    step();
    tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h00010004) begin fails++; $display("FAIL rm_pre got v=%h req=%h addr=%h want 1 1 00010004", instr_valid, imem_req, imem_addr); end
    reset = 1'b0; imem_data = 32'h00010004;
    step();
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h00010000) begin fails++; $display("FAIL rm_reset got v=%h req=%h addr=%h want 0 0 00010000", instr_valid, imem_req, imem_addr); end
    reset = 1'b1;
    step();
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00010000) begin fails++; $display("FAIL rm_release got v=%h req=%h addr=%h want 0 1 00010000", instr_valid, imem_req, imem_addr); end
    imem_data = 32'h00010000;
    step();
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00010000) begin fails++; $display("FAIL rm_out got v=%h pc=%h want 1 00010000", instr_valid, instr_pc); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFFFFF8; wexp[1] = 32'hFFFFFFFC; wexp[2] = 32'h00000000;
    w_reset = 1'b0; w_imem_ack = 1'b0; w_instr_ready = 1'b1;
    step(); step();
    w_reset = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      tests++; if (w_imem_req !== 1'b1 || w_imem_addr !== wexp[k]) begin fails++; $display("FAIL wrap_addr%0d got req=%h addr=%h want 1 %h", k, w_imem_req, w_imem_addr, wexp[k]); end
      w_imem_ack = 1'b1; w_imem_data = wexp[k];
      step();
      tests++; if (w_instr_valid !== 1'b1 || w_instr_pc !== wexp[k] || w_instr_out !== wexp[k]) begin fails++; $display("FAIL wrap_pc%0d got v=%h pc=%h out=%h want 1 %h", k, w_instr_valid, w_instr_pc, w_instr_out, wexp[k]); end
    end
    w_imem_ack = 1'b0;
    $display("[TB] test_wrap done");
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; imem_ack = 1'b0; imem_data = '0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    w_reset = 1'b0; w_imem_ack = 1'b0; w_imem_data = '0; w_redirect_valid = 1'b0;
    w_redirect_pc = '0; w_instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_ack_pop();
    test_redirect_full();
    test_flush_double();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
